calib_pipe: RTL and testbench
=============================

# calib_pipe

Pipelined, multi-channel offset/gain calibration stage for the DSO sample path. It sits between the ADC capture logic and the trigger/capture RAM. Each sample is tagged with a channel number; the block corrects it as clamp(raw + offset) × gain >> FRAC and saturates the result. Per-channel coefficients are written at run time by the EEPROM reader through a write port. Samples flow through a valid/ready stream.

## Interface
- `W`, 8: sample width (unsigned raw and corrected data).
- `GW`, 8: gain width (unsigned, fixed point with FRAC fraction bits).
- `FRAC`, 7: gain fraction bits; unity gain = 1<<FRAC; requires FRAC < W+GW.
- `NCH`, 3: channel count; `CH_W` = max(1, $clog2(NCH)).
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  block can accept a sample.
- `in_ch`  in  CH_W  channel tag of the input sample.
- `in_raw`  in  W  raw unsigned sample.
- `out_valid`  out  1  corrected sample valid.
- `out_ready`  in  1  downstream accepts.
- `out_ch`  out  CH_W  channel tag, carried through.
- `out_data`  out  W  corrected sample.
- `cw_en`  in  1  coefficient write strobe.
- `cw_ch`  in  CH_W  channel to write.
- `cw_sel`  in  1  0 = offset (signed W, low W bits of cw_data), 1 = gain (unsigned GW, low GW bits).
- `cw_data`  in  max(W,GW)  coefficient value.
- `bypass`  in  1  1 = pass in_raw through unmodified (still pipelined).
- `cal_ok`  out  NCH  bit c = both offset and gain of channel c written since reset.

## Operation
- Coefficient reset values: offset = 0, gain = 1<<FRAC, cal_ok = 0.
- Writes with cw_ch ≥ NCH are ignored.
- A sample with in_ch ≥ NCH uses offset 0 and unity gain. Its tag is passed through unchanged.
- S1 (transfer accepted: in_valid & in_ready):
  - Latch ch, bypass and the selected channel's coefficients.
  - Form sum = raw + sign-extended offset in W+2 bits, signed.
  - Clamp the sum to [0, 2^W−1].
- S2: product = clamped_sum × gain, W+GW bits, unsigned.
- S3:
  - Compute p >> FRAC.
  - If the result exceeds 2^W−1, output 2^W−1; otherwise output the low W bits.
  - In bypass, out_data = raw.
- Coefficients are sampled at S1 acceptance. A write in the same cycle as an accepted sample on the same channel does not affect that sample; it affects the next one.
- cal_ok[c] sets when the second of the two coefficient kinds for channel c has been written. It stays set until reset.

## Timing
- Three-stage pipeline. Latency is 3 cycles from accepted input to out_valid with out_ready held high. Throughput is 1 sample per cycle.
- Global stall: advance = ~out_valid | out_ready, and in_ready = advance. All stages hold when advance = 0. Internal bubbles are not collapsed.
- Each stage keeps its own valid bit. All valids reset to 0.
- Reset values: out_valid = 0, out_data = 0, out_ch = 0, cal_ok = 0. in_ready = 1 from the first cycle after reset.
- While out_valid & ~out_ready, out_data and out_ch hold stable.
- Reset mid-stream: all in-flight samples are discarded and coefficients return to their defaults asynchronously. No sample is emitted after reset with pre-reset data.
- Coefficient writes are accepted every cycle regardless of stall.

## Structure
- Package `calib_pkg` holds:
  - enum `cw_sel_e` {CW_OFF, CW_GAIN};
  - default parameter constants;
  - a function `unity_gain(GW, FRAC)`;
  - a function `sat_u(value, W)` for unsigned saturation.
- Sub-module `calib_coef_rf` is the NCH-entry offset/gain register file with a write port, a combinational read port and cal_ok tracking.
- The top level `calib_pipe` holds the three pipeline stages and the stall logic.

## Test plan
Defaults: W=8, GW=8, FRAC=7, NCH=3.
1. After reset, stream ch0 raw=0x40 → out_data=0x40, out_ch=0 exactly 3 cycles later; cal_ok=3'b000.
2. Offset clamping:
   - ch1 offset=+0x10, gain=0x80, raw=0xF8 → 0xFF.
   - ch1 offset=0xF0 (−16), raw=0x05 → 0x00.
   - ch1 offset=0xF0, raw=0x85 → 0x75.
   - cal_ok[1]=1 after both writes.
3. Gain saturation and attenuation, ch2 offset 0:
   - gain=0xFF, raw=0x90 → 0xFF (286 saturated).
   - gain=0x40, raw=0x90 → 0x48.
   - bypass=1 with the same inputs → 0x90.
4. Backpressure: 6 back-to-back samples with out_ready low for cycles 2–6 → in_ready low while stalled, all 6 outputs emitted in order, no loss or duplication, out_data stable while stalled.
5. Write/sample collision: write ch0 gain=0x40 in the same cycle ch0 raw=0x80 is accepted → that sample gives 0x80, the next ch0 raw=0x80 gives 0x40. A write with cw_ch=3 is ignored.
6. Assert rst while 3 samples are in flight → out_valid=0 immediately, no stale output after release, ch1 back to unity gain (raw=0x33 → 0x33), cal_ok=0.

Source files
------------

// File: rtl/calib_pkg.sv
// Shared types, default parameters and helpers for the calibration pipeline.
package calib_pkg;

  typedef enum logic {
    CW_OFF  = 1'b0,
    CW_GAIN = 1'b1
  } cw_sel_e;

  localparam int DEF_W    = 8;
  localparam int DEF_GW   = 8;
  localparam int DEF_FRAC = 7;
  localparam int DEF_NCH  = 3;

  // Unity gain in GW-bit fixed point; saturates if 1<<frac does not fit in gw bits.
  function automatic logic [31:0] unity_gain(input int gw, input int frac);
    logic [31:0] u;
    if (frac < gw) u = 32'd1 << frac;
    else           u = (32'd1 << gw) - 32'd1;
    return u;
  endfunction

  // Clamp an unsigned value to the largest w-bit number.
  function automatic logic [31:0] sat_u(input logic [31:0] value, input int w);
    logic [31:0] maxv;
    if (w >= 32) maxv = '1;
    else         maxv = (32'd1 << w) - 32'd1;
    return (value > maxv) ? maxv : value;
  endfunction

endpackage

// File: rtl/calib_coef_rf.sv
// Per-channel offset/gain register file with write port, combinational read
// port and tracking of which channels have received both coefficients.
module calib_coef_rf
  import calib_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int GW   = DEF_GW,
  parameter int FRAC = DEF_FRAC,
  parameter int NCH  = DEF_NCH,
  localparam int CH_W = ($clog2(NCH) > 1) ? $clog2(NCH) : 1,
  localparam int CW_W = (W > GW) ? W : GW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cw_en,
  input  logic [CH_W-1:0] cw_ch,
  input  cw_sel_e         cw_sel,
  input  logic [CW_W-1:0] cw_data,
  input  logic [CH_W-1:0] rd_ch,
  output logic [W-1:0]    rd_off,
  output logic [GW-1:0]   rd_gain,
  output logic [NCH-1:0]  cal_ok
);

  localparam logic [GW-1:0] UNITY = GW'(unity_gain(GW, FRAC));
  localparam logic [CH_W:0] NCH_V = (CH_W+1)'(NCH);

  logic [W-1:0]   off_q  [NCH];
  logic [GW-1:0]  gain_q [NCH];
  logic [NCH-1:0] off_wr;
  logic [NCH-1:0] gain_wr;
  logic           wr_hit;
  logic           rd_hit;

  assign wr_hit = cw_en && ({1'b0, cw_ch} < NCH_V);
  assign rd_hit = {1'b0, rd_ch} < NCH_V;
  assign cal_ok = off_wr & gain_wr;

  // Coefficient storage; out-of-range channels are dropped, reset restores defaults.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        off_q[i]  <= '0;
        gain_q[i] <= UNITY;
      end
      off_wr  <= '0;
      gain_wr <= '0;
    end else if (wr_hit) begin
      if (cw_sel == CW_GAIN) begin
        gain_q[cw_ch]  <= cw_data[GW-1:0];
        gain_wr[cw_ch] <= 1'b1;
      end else begin
        off_q[cw_ch]  <= cw_data[W-1:0];
        off_wr[cw_ch] <= 1'b1;
      end
    end
  end

  // Read port; unknown channels see zero offset and unity gain.
  always_comb begin
    rd_off  = '0;
    rd_gain = UNITY;
    if (rd_hit) begin
      rd_off  = off_q[rd_ch];
      rd_gain = gain_q[rd_ch];
    end
  end

endmodule

// File: rtl/calib_pipe.sv
// Three-stage offset/gain calibration pipeline with a global stall:
// S1 adds and clamps the offset, S2 multiplies by gain, S3 scales and saturates.
module calib_pipe
  import calib_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int GW   = DEF_GW,
  parameter int FRAC = DEF_FRAC,
  parameter int NCH  = DEF_NCH,
  localparam int CH_W = ($clog2(NCH) > 1) ? $clog2(NCH) : 1,
  localparam int CW_W = (W > GW) ? W : GW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH_W-1:0] in_ch,
  input  logic [W-1:0]    in_raw,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH_W-1:0] out_ch,
  output logic [W-1:0]    out_data,
  input  logic            cw_en,
  input  logic [CH_W-1:0] cw_ch,
  input  logic            cw_sel,
  input  logic [CW_W-1:0] cw_data,
  input  logic            bypass,
  output logic [NCH-1:0]  cal_ok
);

  logic [W-1:0]        rd_off;
  logic [GW-1:0]       rd_gain;
  logic                advance;
  logic signed [W+1:0] sum;
  logic [W-1:0]        clamped;

  logic                v1;
  logic [CH_W-1:0]     ch1;
  logic                byp1;
  logic [W-1:0]        raw1;
  logic [W-1:0]        sum1;
  logic [GW-1:0]       gain1;

  logic                v2;
  logic [CH_W-1:0]     ch2;
  logic                byp2;
  logic [W-1:0]        raw2;
  logic [W+GW-1:0]     prod2;

  logic [W+GW-1:0]     shifted;
  logic [W-1:0]        corrected;

  calib_coef_rf #(.W(W), .GW(GW), .FRAC(FRAC), .NCH(NCH)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .cw_en   (cw_en),
    .cw_ch   (cw_ch),
    .cw_sel  (cw_sel_e'(cw_sel)),
    .cw_data (cw_data),
    .rd_ch   (in_ch),
    .rd_off  (rd_off),
    .rd_gain (rd_gain),
    .cal_ok  (cal_ok)
  );

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Raw plus sign-extended offset, clamped into the unsigned sample range.
  always_comb begin
    sum     = $signed({2'b00, in_raw}) + $signed({{2{rd_off[W-1]}}, rd_off});
    clamped = sum[W+1] ? '0 : (sum[W] ? '1 : sum[W-1:0]);
  end

  // Drop the fraction bits and saturate to the sample width.
  always_comb begin
    shifted   = prod2 >> FRAC;
    corrected = W'(sat_u(32'(shifted), W));
  end

  // S1: capture the accepted sample with the coefficients current at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      ch1   <= '0;
      byp1  <= 1'b0;
      raw1  <= '0;
      sum1  <= '0;
      gain1 <= '0;
    end else if (advance) begin
      v1 <= in_valid;
      if (in_valid) begin
        ch1   <= in_ch;
        byp1  <= bypass;
        raw1  <= in_raw;
        sum1  <= clamped;
        gain1 <= rd_gain;
      end
    end
  end

  // S2: unsigned full-width product of clamped sum and gain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      ch2   <= '0;
      byp2  <= 1'b0;
      raw2  <= '0;
      prod2 <= '0;
    end else if (advance) begin
      v2 <= v1;
      if (v1) begin
        ch2   <= ch1;
        byp2  <= byp1;
        raw2  <= raw1;
        prod2 <= {{GW{1'b0}}, sum1} * {{W{1'b0}}, gain1};
      end
    end
  end

  // S3: output register, holds while downstream is not ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
    end else if (advance) begin
      out_valid <= v2;
      if (v2) begin
        out_ch   <= ch2;
        out_data <= byp2 ? raw2 : corrected;
      end
    end
  end

endmodule

// File: tb/tb_calib_pipe.sv
// Directed self-checking bench for calib_pipe with default parameters.
module tb_calib_pipe;
  import calib_pkg::*;

  localparam int W    = 8;
  localparam int GW   = 8;
  localparam int FRAC = 7;
  localparam int NCH  = 3;
  localparam int CH_W = 2;
  localparam int CW_W = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [CH_W-1:0] in_ch;
  logic [W-1:0]    in_raw;
  logic            out_valid;
  logic            out_ready;
  logic [CH_W-1:0] out_ch;
  logic [W-1:0]    out_data;
  logic            cw_en;
  logic [CH_W-1:0] cw_ch;
  logic            cw_sel;
  logic [CW_W-1:0] cw_data;
  logic            bypass;
  logic [NCH-1:0]  cal_ok;

  int compareCount  = 0;
  int mismatchCount = 0;

  logic [W-1:0]    gotData[$];
  logic [CH_W-1:0] gotCh[$];
  logic [W-1:0]    expData[$];
  logic [CH_W-1:0] expCh[$];

  always #5 clk = ~clk;

  calib_pipe #(.W(W), .GW(GW), .FRAC(FRAC), .NCH(NCH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_raw    (in_raw),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .cw_en     (cw_en),
    .cw_ch     (cw_ch),
    .cw_sel    (cw_sel),
    .cw_data   (cw_data),
    .bypass    (bypass),
    .cal_ok    (cal_ok)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Record every output transfer; inputs only change just after posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      gotData.push_back(out_data);
      gotCh.push_back(out_ch);
    end
  end

  // Present one sample, hold it until accepted, and queue its expected result.
  task automatic applyStimulus(input logic [CH_W-1:0] ch, input logic [W-1:0] raw,
                               input logic byp, input logic [W-1:0] expD);
    int waitCycles;
    waitCycles = 0;
    in_valid = 1'b1;
    in_ch    = ch;
    in_raw   = raw;
    bypass   = byp;
    @(negedge clk);
    while (!in_ready && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    else begin
      expData.push_back(expD);
      expCh.push_back(ch);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bypass   = 1'b0;
  endtask

  task automatic writeCoef(input logic [CH_W-1:0] ch, input logic sel, input logic [CW_W-1:0] data);
    cw_en   = 1'b1;
    cw_ch   = ch;
    cw_sel  = sel;
    cw_data = data;
    @(posedge clk);
    #1;
    cw_en = 1'b0;
  endtask

  // Wait for outstanding outputs, then compare the recorded stream with the expected one.
  task automatic drainAndCompare(input string tag);
    int waitCycles;
    int n;
    waitCycles = 0;
    while (gotData.size() < expData.size() && waitCycles < 60) begin
      @(negedge clk);
      waitCycles++;
    end
    repeat (4) @(negedge clk);
    checkOutput($sformatf("%s_count", tag), 32'(gotData.size()), 32'(expData.size()));
    n = (gotData.size() < expData.size()) ? gotData.size() : expData.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s[%0d]_data", tag, i), 32'(gotData[i]), 32'(expData[i]));
      checkOutput($sformatf("%s[%0d]_ch", tag, i), 32'(gotCh[i]), 32'(expCh[i]));
    end
    gotData.delete();
    gotCh.delete();
    expData.delete();
    expCh.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [W-1:0] raws [6];
    int           idx;
    int           stallCycles;
    logic [W-1:0] heldData;
    logic [CH_W-1:0] heldCh;
    logic         haveHeld;
    logic         accepted;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_ch     = '0;
    in_raw    = '0;
    out_ready = 1'b1;
    cw_en     = 1'b0;
    cw_ch     = '0;
    cw_sel    = 1'b0;
    cw_data   = '0;
    bypass    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_ch", 32'(out_ch), 32'd0);
    checkOutput("rst_cal_ok", 32'(cal_ok), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] test 1: latency");
    applyStimulus(2'd0, 8'h40, 1'b0, 8'h40);
    checkOutput("lat_edge1_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_edge2_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_edge3_valid", 32'(out_valid), 32'd1);
    checkOutput("lat_data", 32'(out_data), 32'h40);
    checkOutput("lat_ch", 32'(out_ch), 32'd0);
    checkOutput("lat_cal_ok", 32'(cal_ok), 32'd0);
    drainAndCompare("t1");

    $display("[TB] test 2: offset clamping");
    writeCoef(2'd1, 1'b0, 8'h10);
    writeCoef(2'd1, 1'b1, 8'h80);
    applyStimulus(2'd1, 8'hF8, 1'b0, 8'hFF);
    writeCoef(2'd1, 1'b0, 8'hF0);
    applyStimulus(2'd1, 8'h05, 1'b0, 8'h00);
    applyStimulus(2'd1, 8'h85, 1'b0, 8'h75);
    checkOutput("t2_cal_ok", 32'(cal_ok), 32'b010);
    drainAndCompare("t2");

    $display("[TB] test 3: gain saturation and bypass");
    writeCoef(2'd2, 1'b0, 8'h00);
    writeCoef(2'd2, 1'b1, 8'hFF);
    applyStimulus(2'd2, 8'h90, 1'b0, 8'hFF);
    writeCoef(2'd2, 1'b1, 8'h40);
    applyStimulus(2'd2, 8'h90, 1'b0, 8'h48);
    applyStimulus(2'd2, 8'h90, 1'b1, 8'h90);
    checkOutput("t3_cal_ok", 32'(cal_ok), 32'b110);
    drainAndCompare("t3");

    $display("[TB] test 4: backpressure");
    raws = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    idx         = 0;
    stallCycles = 0;
    haveHeld    = 1'b0;
    heldData    = '0;
    heldCh      = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      out_ready = !(cyc >= 2 && cyc <= 6);
      in_valid  = (idx < 6);
      in_ch     = 2'd0;
      in_raw    = (idx < 6) ? raws[idx] : '0;
      @(negedge clk);
      accepted = in_valid && in_ready;
      if (out_valid && !out_ready) begin
        stallCycles++;
        checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        if (haveHeld) begin
          checkOutput("bp_hold_data", 32'(out_data), 32'(heldData));
          checkOutput("bp_hold_ch", 32'(out_ch), 32'(heldCh));
        end
        heldData = out_data;
        heldCh   = out_ch;
        haveHeld = 1'b1;
      end else begin
        haveHeld = 1'b0;
      end
      if (accepted) begin
        expData.push_back(raws[idx]);
        expCh.push_back(2'd0);
        idx++;
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("bp_stall_cycles", 32'(stallCycles), 32'd4);
    drainAndCompare("t4");

    $display("[TB] test 5: write/sample collision");
    cw_en   = 1'b1;
    cw_ch   = 2'd0;
    cw_sel  = 1'b1;
    cw_data = 8'h40;
    applyStimulus(2'd0, 8'h80, 1'b0, 8'h80);
    cw_en = 1'b0;
    applyStimulus(2'd0, 8'h80, 1'b0, 8'h40);
    writeCoef(2'd3, 1'b1, 8'h40);
    writeCoef(2'd3, 1'b0, 8'h10);
    checkOutput("t5_cal_ok_ignored", 32'(cal_ok), 32'b110);
    applyStimulus(2'd3, 8'h33, 1'b0, 8'h33);
    drainAndCompare("t5");
    writeCoef(2'd0, 1'b0, 8'h00);
    checkOutput("t5_cal_ok_all", 32'(cal_ok), 32'b111);

    $display("[TB] test 6: reset mid-stream");
    applyStimulus(2'd1, 8'h11, 1'b0, 8'h00);
    applyStimulus(2'd1, 8'h22, 1'b0, 8'h00);
    applyStimulus(2'd1, 8'h33, 1'b0, 8'h00);
    checkOutput("t6_pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_async_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_rst_cal_ok", 32'(cal_ok), 32'd0);
    gotData.delete();
    gotCh.delete();
    expData.delete();
    expCh.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("t6_no_stale", 32'(gotData.size()), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(2'd1, 8'h33, 1'b0, 8'h33);
    drainAndCompare("t6");
    checkOutput("t6_cal_ok_after", 32'(cal_ok), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
